mux_nsel_pipe: RTL

Parametrised, registered N:1 operand selector with valid/ready handshake and an auto-scan mode. It sits in front of the modular multiply/divide datapath. It replaces fixed combinational 6:1 selects wherever operands must be delivered one per cycle under back-pressure, or all channels streamed in order.

---
 rtl/muxsel_pkg.sv | 23 ++
 rtl/muxsel_skid.sv | 56 +++++
 rtl/mux_nsel_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/muxsel_pkg.sv
// Shared definitions for the mux_nsel_pipe operand selector: FSM encoding,
// packed beat layout {data, idx, last, err} and the out-of-range data constant.
package muxsel_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Beat bit positions from the LSB: err, last, idx[SW], data[W]
    localparam int BEAT_ERR_BIT  = 0;
    localparam int BEAT_LAST_BIT = 1;
    localparam int BEAT_IDX_LSB  = 2;
    localparam int BEAT_CTL_W    = 2;

    // Replicated to W bits for a select that names no channel
    localparam logic ZERO_BIT = 1'b0;

    function automatic int beat_data_lsb(input int sw);
        return BEAT_IDX_LSB + sw;
    endfunction

endpackage

// File: rtl/muxsel_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready is a pure register decode,
// so no combinational path runs from out_ready back to the producer.
module muxsel_skid #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [BW-1:0] head_p1;
    logic [BW-1:0] spare_p1;
    logic          vld_head_p1;
    logic          vld_spare_p1;
    logic          push;
    logic          pop;

    // The spare slot only fills while the head is occupied, so it doubles as "full"
    assign in_ready  = !vld_spare_p1;
    assign push      = in_valid && !vld_spare_p1;
    assign pop       = vld_head_p1 && out_ready;
    assign out_data  = head_p1;
    assign out_valid = vld_head_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_p1      <= '0;
            spare_p1     <= '0;
            vld_head_p1  <= 1'b0;
            vld_spare_p1 <= 1'b0;
        end else if (vld_spare_p1) begin
            if (pop) begin
                head_p1      <= spare_p1;
                vld_spare_p1 <= 1'b0;
            end
        end else if (vld_head_p1) begin
            if (push && pop) begin
                head_p1 <= in_data;
            end else if (push) begin
                spare_p1     <= in_data;
                vld_spare_p1 <= 1'b1;
            end else if (pop) begin
                vld_head_p1 <= 1'b0;
            end
        end else if (push) begin
            head_p1     <= in_data;
            vld_head_p1 <= 1'b1;
        end
    end

endmodule

// File: rtl/mux_nsel_pipe.sv
// Registered N:1 operand selector with valid/ready handshake and in-order scan.
// Define MUXSEL_SKID_EN to put a 2-entry skid buffer on the output.
module mux_nsel_pipe
    import muxsel_pkg::*;
#(
    parameter int W  = 32,
    parameter int N  = 6,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_flat,
    input  logic [SW-1:0]  sel,
    input  logic           sel_valid,
    output logic           sel_ready,
    input  logic           scan_start,
    output logic           scan_busy,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_idx,
    output logic           out_last,
    output logic           out_err,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int          BW       = W + SW + BEAT_CTL_W;
    localparam int          DATA_LSB = beat_data_lsb(SW);
    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

    function automatic logic [BW-1:0] pack_beat(input logic [W-1:0] data,
                                                input logic [SW-1:0] idx,
                                                input logic last,
                                                input logic err);
        return {data, idx, last, err};
    endfunction

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;
    logic [W-1:0]  chan [N];
    logic          sel_oor;
    logic          slot_free;
    logic          load_p0;
    logic [BW-1:0] beat_p0;
    logic [BW-1:0] beat_p1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            chan[i] = in_flat[i*W +: W];
        end
    end

    assign sel_oor   = ({1'b0, sel} >= (SW+1)'(N));
    assign scan_busy = (state_q == ST_SCAN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_p0   = 1'b0;
        beat_p0   = '0;
        sel_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A scan request pre-empts any direct request in the same cycle
                sel_ready = slot_free && !scan_start;
                if (scan_start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else if (sel_valid && slot_free) begin
                    load_p0 = 1'b1;
                    beat_p0 = pack_beat(sel_oor ? {W{ZERO_BIT}} : chan[sel],
                                        sel, 1'b0, sel_oor);
                end
            end
            ST_SCAN: begin
                if (slot_free) begin
                    load_p0 = 1'b1;
                    beat_p0 = pack_beat(chan[cnt_q], cnt_q, cnt_q == LAST_IDX, 1'b0);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- stage p0 -> p1: beat capture into the output slot ----
`ifdef MUXSEL_SKID_EN
    logic skid_ready;

    muxsel_skid #(
        .BW(BW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (beat_p0),
        .in_valid (load_p0),
        .in_ready (skid_ready),
        .out_data (beat_p1),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign slot_free = skid_ready;
`else
    logic vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (load_p0) begin
            beat_p1 <= beat_p0;
            vld_p1  <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign slot_free = !vld_p1 || out_ready;
`endif

    assign out_data = beat_p1[DATA_LSB +: W];
    assign out_idx  = beat_p1[BEAT_IDX_LSB +: SW];
    assign out_last = beat_p1[BEAT_LAST_BIT];
    assign out_err  = beat_p1[BEAT_ERR_BIT];

endmodule
